// File: rtl/gr8_ctrl_pkg.sv
// Shared types and constants for the front-panel step/run controller.
package gr8_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } press_state_t;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/ce_divider.sv
// Free-running divider for RUN mode; tick strobes on the terminal count.
module ce_divider #(
  parameter int unsigned RUN_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(RUN_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = enable & ~clear & (div_cnt == LAST);

  // Count 0..RUN_DIV-1 while enabled, hold at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (div_cnt == LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_controller.sv
// CPU clock-enable sequencer: single step on short press, RUN/STEP toggle on
// long press, divided-rate pulses in RUN, halt forces STEP.
module step_controller
  import gr8_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV     = 1024,
  parameter int unsigned LONG_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic halt,
  output logic cpu_ce,
  output logic run_mode,
  output logic busy
);

  localparam int unsigned PW = $clog2(LONG_CYCLES);
  localparam logic [PW-1:0] PRESS_LAST = PW'(LONG_CYCLES - 2);

  press_state_t  state, state_next;
  logic [PW-1:0] press_cnt, press_cnt_next;
  logic          btn_q;
  logic          rise;
  logic          toggle;
  logic          step_req;
  logic          run_tick;
  logic          run_mode_next;
  logic          ce_next;

  assign rise = btn & ~btn_q;

  ce_divider #(
    .RUN_DIV(RUN_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .enable(run_mode),
    .clear (~run_mode | halt),
    .tick  (run_tick)
  );

  // Press classification, mode update and combined clock-enable request.
  always_comb begin
    state_next     = state;
    press_cnt_next = press_cnt;
    toggle         = 1'b0;
    step_req       = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next     = PRESS;
          press_cnt_next = '0;
        end
      end
      PRESS: begin
        if (!btn) begin
          state_next = IDLE;
          step_req   = (run_mode == MODE_STEP) & ~halt;
        end else if (press_cnt == PRESS_LAST) begin
          state_next = HELD;
          toggle     = 1'b1;
        end else begin
          press_cnt_next = press_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Halt dominates: it both clears RUN and blocks a STEP->RUN toggle.
    if (halt) begin
      run_mode_next = MODE_STEP;
    end else if (toggle) begin
      run_mode_next = ~run_mode;
    end else begin
      run_mode_next = run_mode;
    end

    // A toggle out of RUN on a terminal count swallows that pulse.
    ce_next = (step_req | (run_tick & ~toggle)) & ~halt;
  end

  // State, mode and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      press_cnt <= '0;
      btn_q     <= 1'b0;
      run_mode  <= MODE_STEP;
      cpu_ce    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      press_cnt <= press_cnt_next;
      btn_q     <= btn;
      run_mode  <= run_mode_next;
      cpu_ce    <= ce_next;
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller with RUN_DIV=4, LONG_CYCLES=8.
module tb_step_controller;

  localparam int RUN_DIV = 4;
  localparam int LONG    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0;
  logic halt = 1'b0;
  logic cpu_ce, run_mode, busy;

  int errors = 0;
  int checks = 0;

  // Behavioural reference state: press length in sampled-high cycles and
  // the number of unhalted cycles spent in RUN.
  bit m_pressing, m_long, m_prev, m_mode, m_ce, m_busy;
  int m_held, m_age;

  step_controller #(
    .RUN_DIV    (RUN_DIV),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .halt    (halt),
    .cpu_ce  (cpu_ce),
    .run_mode(run_mode),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit b, input bit h, input bit r);
    bit toggle;
    toggle = 0;
    m_ce   = 0;
    if (r) begin
      m_pressing = 0; m_long = 0; m_prev = 0; m_mode = 0;
      m_busy = 0; m_held = 0; m_age = 0;
    end else begin
      if (!m_pressing) begin
        if (b && !m_prev) begin
          m_pressing = 1; m_held = 1; m_long = 0;
        end
      end else if (!b) begin
        if (!m_long && !m_mode && !h) m_ce = 1;
        m_pressing = 0;
      end else if (!m_long) begin
        m_held++;
        if (m_held == LONG) begin
          m_long = 1;
          toggle = 1;
        end
      end
      if (m_mode && !h && !toggle) begin
        m_age++;
        if (m_age % RUN_DIV == 0) m_ce = 1;
      end else begin
        m_age = 0;
      end
      m_mode = h ? 1'b0 : (toggle ? !m_mode : m_mode);
      m_busy = m_pressing;
      m_prev = b;
    end
  endtask

  // Drive one cycle of inputs, advance the model with them, sample after the edge.
  task automatic cyc(input bit b, input bit h, input bit r);
    btn = b; halt = h; reset = r;
    @(posedge clk);
    model_edge(b, h, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      checks++;
      if ({cpu_ce, run_mode, busy} !== 3'b000) begin
        errors++;
        $display("FAIL reset cyc%0d: ce/run/busy=%b%b%b required 000", i, cpu_ce, run_mode, busy);
      end
    end
  endtask

  task automatic test_step_press();
    int pulses = 0, busy_n = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(i < 3, 0, 0);
      pulses += int'(cpu_ce);
      busy_n += int'(busy);
      checks++;
      if ({cpu_ce, run_mode, busy} !== {m_ce, m_mode, m_busy}) begin
        errors++;
        $display("FAIL step_press cyc%0d: ce/run/busy=%b%b%b required %b%b%b",
                 i, cpu_ce, run_mode, busy, m_ce, m_mode, m_busy);
      end
      if (i == 3) begin
        checks++;
        if (cpu_ce !== 1'b1) begin
          errors++;
          $display("FAIL step_press_timing: cpu_ce=%b after release required 1", cpu_ce);
        end
      end
    end
    checks++;
    if (pulses != 1 || busy_n != 3) begin
      errors++;
      $display("FAIL step_press_counts: pulses=%0d busy_cycles=%0d required 1 and 3", pulses, busy_n);
    end
  endtask

  task automatic test_long_run();
    int pulses = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(i < 12, 0, 0);
      pulses += int'(cpu_ce);
      checks++;
      if ({cpu_ce, run_mode, busy} !== {m_ce, m_mode, m_busy}) begin
        errors++;
        $display("FAIL long_run cyc%0d: ce/run/busy=%b%b%b required %b%b%b",
                 i, cpu_ce, run_mode, busy, m_ce, m_mode, m_busy);
      end
      if (i == 6 || i == 7) begin
        checks++;
        if (run_mode !== (i == 7)) begin
          errors++;
          $display("FAIL long_run_toggle cyc%0d: run_mode=%b required %b", i, run_mode, i == 7);
        end
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL long_run_pulses: got %0d required 4", pulses);
    end
  endtask

  task automatic test_halt();
    int pulses = 0, stepped = 0;
    for (int i = 0; i < 21; i++) begin
      // halt pulse, quiet gap, short press under halt, short press without
      case (1'b1)
        (i == 0):           cyc(0, 1, 0);
        (i < 11):           cyc(0, 0, 0);
        (i < 13):           cyc(1, 1, 0);
        (i == 13):          cyc(0, 1, 0);
        (i < 16):           cyc(0, 0, 0);
        (i < 18):           cyc(1, 0, 0);
        default:            cyc(0, 0, 0);
      endcase
      if (i < 16) pulses += int'(cpu_ce);
      else stepped += int'(cpu_ce);
      checks++;
      if ({cpu_ce, run_mode, busy} !== {m_ce, m_mode, m_busy}) begin
        errors++;
        $display("FAIL halt cyc%0d: ce/run/busy=%b%b%b required %b%b%b",
                 i, cpu_ce, run_mode, busy, m_ce, m_mode, m_busy);
      end
    end
    checks++;
    if (pulses != 0 || stepped != 1) begin
      errors++;
      $display("FAIL halt_counts: halted_pulses=%0d later_steps=%0d required 0 and 1", pulses, stepped);
    end
  endtask

  task automatic test_halt_long();
    int pulses = 0, busy_n = 0, runs = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(i < 10, i < 12, 0);
      pulses += int'(cpu_ce);
      busy_n += int'(busy);
      runs   += int'(run_mode);
      checks++;
      if ({cpu_ce, run_mode, busy} !== {m_ce, m_mode, m_busy}) begin
        errors++;
        $display("FAIL halt_long cyc%0d: ce/run/busy=%b%b%b required %b%b%b",
                 i, cpu_ce, run_mode, busy, m_ce, m_mode, m_busy);
      end
    end
    checks++;
    if (pulses != 0 || busy_n != 10 || runs != 0) begin
      errors++;
      $display("FAIL halt_long_counts: pulses=%0d busy=%0d run=%0d required 0,10,0", pulses, busy_n, runs);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    // 5-cycle hold, reset; long press into RUN, reset; then a 2-cycle press
    for (int i = 0; i < 30; i++) begin
      case (1'b1)
        (i < 5):   cyc(1, 0, 0);
        (i == 5):  cyc(0, 0, 1);
        (i < 14):  cyc(1, 0, 0);
        (i < 19):  cyc(0, 0, 0);
        (i == 19): cyc(0, 0, 1);
        (i < 23):  cyc(0, 0, 0);
        (i < 25):  cyc(1, 0, 0);
        default:   cyc(0, 0, 0);
      endcase
      if (i >= 20) pulses += int'(cpu_ce);
      checks++;
      if ({cpu_ce, run_mode, busy} !== {m_ce, m_mode, m_busy}) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: ce/run/busy=%b%b%b required %b%b%b",
                 i, cpu_ce, run_mode, busy, m_ce, m_mode, m_busy);
      end
      if (i == 5 || i == 19) begin
        checks++;
        if ({cpu_ce, run_mode, busy} !== 3'b000) begin
          errors++;
          $display("FAIL reset_mid_zero cyc%0d: ce/run/busy=%b%b%b required 000", i, cpu_ce, run_mode, busy);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL reset_mid_step: pulses=%0d required 1", pulses);
    end
  endtask

  task automatic test_toggle_tc();
    for (int i = 0; i < 28; i++) begin
      cyc((i < 12) || (i >= 16 && i < 24), 0, 0);
      checks++;
      if ({cpu_ce, run_mode, busy} !== {m_ce, m_mode, m_busy}) begin
        errors++;
        $display("FAIL toggle_tc cyc%0d: ce/run/busy=%b%b%b required %b%b%b",
                 i, cpu_ce, run_mode, busy, m_ce, m_mode, m_busy);
      end
      if (i == 19 || i == 23) begin
        checks++;
        if ({cpu_ce, run_mode} !== ((i == 19) ? 2'b11 : 2'b00)) begin
          errors++;
          $display("FAIL toggle_tc_edge cyc%0d: ce/run=%b%b required %b",
                   i, cpu_ce, run_mode, (i == 19) ? 2'b11 : 2'b00);
        end
      end
    end
  endtask

  task automatic test_random();
    int n = 0;
    bit b, h, r;
    while (n < 500) begin
      int len;
      b   = ($urandom_range(0, 1) == 1);
      h   = ($urandom_range(0, 7) == 0);
      len = (h || $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 59) == 0);
        cyc(b, h, r);
        n++;
        checks++;
        if ({cpu_ce, run_mode, busy} !== {m_ce, m_mode, m_busy}) begin
          errors++;
          $display("FAIL random cyc%0d: ce/run/busy=%b%b%b required %b%b%b",
                   n, cpu_ce, run_mode, busy, m_ce, m_mode, m_busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_press();
    test_long_run();
    test_halt();
    test_halt_long();
    test_reset_mid();
    test_toggle_tc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
